sprite_motion: RTL and testbench

//  Per-frame sprite position generator feeding sprite (sprx/spry inputs).
//  On each frame strobe it advances the sprite position by a per-axis speed.
//  It bounces off the screen edges on both axes and signals each bounce.

---
 rtl/sprite_motion.sv | 154 +++++++++++++++
 tb/tb_sprite_motion.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion.sv
// Per-frame sprite position generator: advances sprx/spry by a per-axis speed on each frame strobe and bounces off the screen edges.
// Optional build macro SPRITE_MOTION_WRAP_EN makes the x axis wrap around the screen instead of bouncing.
module sprite_motion #(
  parameter int CORDW     = 16,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SPR_DRAWW = 64,
  parameter int SPR_DRAWH = 64,
  parameter int START_X   = 288,
  parameter int START_Y   = 208,
  parameter int SPX_INIT  = 4,
  parameter int SPY_INIT  = 2
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    frame,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_spx,
  input  logic [7:0]              cfg_spy,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic                    dx,
  output logic                    dy,
  output logic                    bounce_x,
  output logic                    bounce_y,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC_X = 2'd1, CALC_Y = 2'd2, COMMIT = 2'd3} state_t;

  localparam logic signed [CORDW:0]   ZERO_W = '0;
  localparam logic signed [CORDW:0]   YMAX_W = (CORDW+1)'(V_RES - SPR_DRAWH);
  localparam logic signed [CORDW-1:0] YMAX_C = CORDW'(V_RES - SPR_DRAWH);
`ifdef SPRITE_MOTION_WRAP_EN
  localparam logic signed [CORDW:0]   HRES_W  = (CORDW+1)'(H_RES);
  localparam logic signed [CORDW:0]   NSPRW_W = (CORDW+1)'(-SPR_DRAWW);
  localparam logic signed [CORDW-1:0] WRAP_C  = CORDW'(H_RES + SPR_DRAWW);
`else
  localparam logic signed [CORDW:0]   XMAX_W = (CORDW+1)'(H_RES - SPR_DRAWW);
  localparam logic signed [CORDW-1:0] XMAX_C = CORDW'(H_RES - SPR_DRAWW);
`endif

  state_t                  state;
  logic [7:0]              spx, spy;
  logic signed [CORDW:0]   spx_w, spy_w, step_x, step_y;
  logic signed [CORDW-1:0] x_calc, y_calc, nx, ny;
  logic                    dx_calc, dy_calc, bx_calc, by_calc;
  logic                    ndx, ndy, nbx, nby;

  // Handshake: a speed pair transfers on a clock edge where cfg_valid && cfg_ready;
  // the block is only ready while idle and not in the frame-strobe cycle.
  assign cfg_ready = (state == IDLE) && !frame;
  assign dbg_state = state;

  assign spx_w = {{(CORDW-7){1'b0}}, spx};
  assign spy_w = {{(CORDW-7){1'b0}}, spy};

  // One extra bit of headroom so the edge compare never sees a wrapped value.
  always_comb begin
    step_x  = dx ? ({sprx[CORDW-1], sprx} - spx_w) : ({sprx[CORDW-1], sprx} + spx_w);
    x_calc  = step_x[CORDW-1:0];
    dx_calc = dx;
    bx_calc = 1'b0;
`ifdef SPRITE_MOTION_WRAP_EN
    if (!dx && step_x >= HRES_W)
      x_calc = step_x[CORDW-1:0] - WRAP_C;
    else if (dx && step_x <= NSPRW_W)
      x_calc = step_x[CORDW-1:0] + WRAP_C;
`else
    if (!dx && step_x >= XMAX_W) begin
      x_calc  = XMAX_C;
      dx_calc = 1'b1;
      bx_calc = 1'b1;
    end else if (dx && step_x <= ZERO_W) begin
      x_calc  = '0;
      dx_calc = 1'b0;
      bx_calc = 1'b1;
    end
`endif
  end

  always_comb begin
    step_y  = dy ? ({spry[CORDW-1], spry} - spy_w) : ({spry[CORDW-1], spry} + spy_w);
    y_calc  = step_y[CORDW-1:0];
    dy_calc = dy;
    by_calc = 1'b0;
    if (!dy && step_y >= YMAX_W) begin
      y_calc  = YMAX_C;
      dy_calc = 1'b1;
      by_calc = 1'b1;
    end else if (dy && step_y <= ZERO_W) begin
      y_calc  = '0;
      dy_calc = 1'b0;
      by_calc = 1'b1;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state    <= IDLE;
      sprx     <= CORDW'(START_X);
      spry     <= CORDW'(START_Y);
      dx       <= 1'b0;
      dy       <= 1'b0;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      spx      <= 8'(SPX_INIT);
      spy      <= 8'(SPY_INIT);
      nx       <= '0;
      ny       <= '0;
      ndx      <= 1'b0;
      ndy      <= 1'b0;
      nbx      <= 1'b0;
      nby      <= 1'b0;
    end else begin
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            spx <= cfg_spx;
            spy <= cfg_spy;
          end
          if (frame && enable) state <= CALC_X;
        end
        CALC_X: begin
          nx    <= x_calc;
          ndx   <= dx_calc;
          nbx   <= bx_calc;
          state <= CALC_Y;
        end
        CALC_Y: begin
          ny    <= y_calc;
          ndy   <= dy_calc;
          nby   <= by_calc;
          state <= COMMIT;
        end
        COMMIT: begin
          sprx     <= nx;
          spry     <= ny;
          dx       <= ndx;
          dy       <= ndy;
          bounce_x <= nbx;
          bounce_y <= nby;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: table of multi-frame motion vectors plus hand sequences for config, lost frames and mid-update reset.
// Expectations follow SPRITE_MOTION_WRAP_EN when the macro is defined for the build.
module tb_sprite_motion;

  logic               clk_pix = 1'b0;
  logic               rst_pix_n = 1'b0;
  logic               frame = 1'b0;
  logic               enable = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [7:0]         cfg_spx = 8'd0;
  logic [7:0]         cfg_spy = 8'd0;
  logic signed [15:0] sprx, spry;
  logic               dx, dy, bounce_x, bounce_y;
  logic [1:0]         dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int bx_cnt = 0;
  int by_cnt = 0;
  int ov_cnt = 0;
  logic frame_ready;

  typedef struct {
    int   frames;
    logic en;
    int   x;
    int   y;
    int   dxv;
    int   dyv;
    int   bxc;
    int   byc;
  } vec_t;

  vec_t vecs[6];

  sprite_motion dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .frame     (frame),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_spx   (cfg_spx),
    .cfg_spy   (cfg_spy),
    .sprx      (sprx),
    .spry      (spry),
    .dx        (dx),
    .dy        (dy),
    .bounce_x  (bounce_x),
    .bounce_y  (bounce_y),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk_pix = ~clk_pix;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_pix);
    #1;
    if (bounce_x) bx_cnt++;
    if (bounce_y) by_cnt++;
    if (bounce_x && bounce_y) ov_cnt++;
  endtask

  task automatic do_reset();
    rst_pix_n = 1'b0;
    frame     = 1'b0;
    enable    = 1'b1;
    cfg_valid = 1'b0;
    tick();
    tick();
    rst_pix_n = 1'b1;
    tick();
    bx_cnt = 0;
    by_cnt = 0;
    ov_cnt = 0;
  endtask

  // Frame strobe then wait until the commit edge has passed.
  task automatic run_frame(input logic en);
    enable = en;
    frame  = 1'b1;
    #1;
    frame_ready = cfg_ready;
    tick();
    frame     = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // scoreboard
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    //              frames en   x    y    dx dy bx by
`ifdef SPRITE_MOTION_WRAP_EN
    vecs[0] = '{1,  1'b1, 292, 210, 0, 0, 0, 0};
    vecs[1] = '{71, 1'b1, 576, 352, 0, 0, 0, 0};
    vecs[2] = '{1,  1'b1, 580, 354, 0, 0, 0, 0};
    vecs[3] = '{10, 1'b0, 580, 354, 0, 0, 0, 0};
    vecs[4] = '{31, 1'b1, 0,   416, 0, 1, 0, 1};
    vecs[5] = '{1,  1'b1, 4,   414, 0, 1, 0, 0};
`else
    vecs[0] = '{1,  1'b1, 292, 210, 0, 0, 0, 0};
    vecs[1] = '{71, 1'b1, 576, 352, 1, 0, 1, 0};
    vecs[2] = '{1,  1'b1, 572, 354, 1, 0, 0, 0};
    vecs[3] = '{10, 1'b0, 572, 354, 1, 0, 0, 0};
    vecs[4] = '{31, 1'b1, 448, 416, 1, 1, 0, 1};
    vecs[5] = '{1,  1'b1, 444, 414, 1, 1, 0, 0};
`endif

    do_reset();
    check("reset_sprx", int'(sprx), 288);
    check("reset_spry", int'(spry), 208);
    check("reset_dx", int'(dx), 0);
    check("reset_dy", int'(dy), 0);
    check("reset_bounce", int'({bounce_x, bounce_y}), 0);
    check("reset_state", int'(dbg_state), 0);
    check("reset_cfg_ready", int'(cfg_ready), 1);

    // Table: cumulative motion at default speeds from reset.
    for (int i = 0; i < 6; i++) begin
      bx_cnt = 0;
      by_cnt = 0;
      for (int f = 0; f < vecs[i].frames; f++) run_frame(vecs[i].en);
      check($sformatf("v%0d_sprx", i), int'(sprx), vecs[i].x);
      check($sformatf("v%0d_spry", i), int'(spry), vecs[i].y);
      check($sformatf("v%0d_dx", i), int'(dx), vecs[i].dxv);
      check($sformatf("v%0d_dy", i), int'(dy), vecs[i].dyv);
      check($sformatf("v%0d_bounce_x_pulses", i), bx_cnt, vecs[i].bxc);
      check($sformatf("v%0d_bounce_y_pulses", i), by_cnt, vecs[i].byc);
    end
    check("bounce_overlap", ov_cnt, 0);

    // Config: spx=0, spy=100 accepted in IDLE; an offer during the frame strobe is refused.
    do_reset();
    cfg_spx   = 8'd0;
    cfg_spy   = 8'd100;
    cfg_valid = 1'b1;
    tick();
    cfg_spx   = 8'd9;
    cfg_spy   = 8'd9;
    cfg_valid = 1'b1;
    run_frame(1'b1);
    check("cfg_ready_on_frame", int'(frame_ready), 0);
    check("cfg_f1_sprx", int'(sprx), 288);
    check("cfg_f1_spry", int'(spry), 308);
    run_frame(1'b1);
    check("cfg_f2_spry", int'(spry), 408);
    by_cnt = 0;
    run_frame(1'b1);
    check("cfg_f3_spry", int'(spry), 416);
    check("cfg_f3_dy", int'(dy), 1);
    check("cfg_f3_bounce_y", by_cnt, 1);
    run_frame(1'b1);
    check("cfg_f4_spry", int'(spry), 316);
    check("cfg_f4_sprx", int'(sprx), 288);
    check("cfg_bounce_x", bx_cnt, 0);

    // A frame arriving while busy is dropped.
    do_reset();
    frame = 1'b1;
    tick();
    tick();
    frame = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("lost_frame_sprx", int'(sprx), 292);
    check("lost_frame_spry", int'(spry), 210);
    check("lost_frame_state", int'(dbg_state), 0);

    // Asynchronous reset during CALC_Y.
    do_reset();
    run_frame(1'b1);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
    check("midrst_state_before", int'(dbg_state), 2);
    check("midrst_hold_before", int'(sprx), 292);
    rst_pix_n = 1'b0;
    #1;
    check("midrst_sprx", int'(sprx), 288);
    check("midrst_spry", int'(spry), 208);
    check("midrst_state", int'(dbg_state), 0);
    tick();
    rst_pix_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("midrst_no_commit_x", int'(sprx), 288);
    check("midrst_no_commit_y", int'(spry), 208);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
